lsu_handshake: RTL and testbench

- Multi-cycle load/store unit. Successor to the single-cycle memory interface in the RV core top.
- Accepts one load/store per request from the core and runs a valid/ready transaction on a data-memory bus with arbitrary wait states.
- Holds the core via stall, then returns a sign/zero-extended load result or a fault code.
- Parametrised in data width (32/64-bit, adds LD/LWU/SD) and in bus timeout.

---
 rtl/lsu_handshake.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_handshake.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_handshake.sv
// lsu_handshake: multi-cycle load/store unit between the core and a data-memory bus.
//
// One access is accepted from the core per request. Each accepted access either
// faults straight away or runs one valid/ready transaction on the memory bus.
// The core is stalled meanwhile. Completion is a one-cycle done pulse carrying a
// fault code and, for loads, a registered sign/zero-extended result.
//
// Handshake semantics (both sides):
//   Core side: an access is taken on the rising edge where req_valid=1 and
//   req_ready=1 and the access is a load or a store. While not ready, the core
//   keeps req_valid and its fields asserted.
//   Memory side: mem_valid, mem_addr, mem_we, mem_wdata and mem_wstrb stay
//   stable from the first BUS cycle until the edge where mem_ready=1. That edge
//   completes the transfer, and mem_rdata is sampled on it. mem_valid is never
//   withdrawn early, except on a bus timeout or on reset.
//
// Ports:
//   clk, rst (async, active low)
//   req_valid, req_ready, is_load, is_store, funct3, addr, wdata : core request
//   rdata, done, fault, stall                                    : core response
//   mem_valid, mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb,
//   mem_rdata                                                    : memory bus
//   state_dbg : current FSM state (0 IDLE, 1 BUS, 2 RESP)
module lsu_handshake #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic [1:0]        fault,
    output logic              stall,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [NB-1:0]     mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;
    localparam logic [1:0] F_ILLEGAL = 2'b11;

    // Wide enough to hold TIMEOUT-1; at least one bit when the timeout is disabled.
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [1:0]          fault_q, fault_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   lat_addr;
    logic [2:0]          lat_f3;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_store;

    logic                accept;
    logic                latch;
    logic                load_rdata;
    logic                f3_legal;
    logic                misaligned;
    logic [1:0]          req_fault;
    logic [OFF_W-1:0]    lat_off;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   ext;
    logic [NB-1:0]       size_mask;
    logic [DATA_W-1:0]   rep_wdata;

    // Gating with rst keeps stall low while reset is held, even if req_valid is high.
    assign accept = rst && (state_q == IDLE) && req_valid && (is_load || is_store);

    // Legality and alignment are judged on the live request at acceptance.
    always_comb begin
        f3_legal = 1'b0;
        if (is_load && is_store) begin
            f3_legal = 1'b0;
        end else if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                3'b011, 3'b110:                         f3_legal = (DATA_W == 64);
                default:                                f3_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                3'b011:                 f3_legal = (DATA_W == 64);
                default:                f3_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
    end

    assign req_fault = !f3_legal ? F_ILLEGAL : (misaligned ? F_MISALIGN : F_OK);

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        load_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    latch = 1'b1;
                    if (req_fault != F_OK) begin
                        state_d = RESP;
                        fault_d = req_fault;
                    end else begin
                        state_d = BUS;
                        cnt_d   = '0;
                    end
                end
            end
            BUS: begin
                if (mem_ready) begin
                    state_d    = RESP;
                    fault_d    = F_OK;
                    load_rdata = !lat_store;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d = RESP;
                    fault_d = F_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            fault_q   <= F_OK;
            cnt_q     <= '0;
            rdata_q   <= '0;
            lat_addr  <= '0;
            lat_f3    <= '0;
            lat_wdata <= '0;
            lat_store <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                lat_addr  <= addr;
                lat_f3    <= funct3;
                lat_wdata <= wdata;
                lat_store <= is_store;
            end
            if (load_rdata) begin
                rdata_q <= ext;
            end
        end
    end

    // Load lane extraction: bring the addressed lane down to bit 0, then extend.
    assign lat_off = lat_addr[OFF_W-1:0];
    assign shifted = mem_rdata >> {lat_off, 3'b000};

    always_comb begin
        ext = shifted;
        case (lat_f3)
            3'b000:  ext = DATA_W'($signed(shifted[7:0]));
            3'b001:  ext = DATA_W'($signed(shifted[15:0]));
            3'b010:  ext = DATA_W'($signed(shifted[31:0]));
            3'b100:  ext = DATA_W'(shifted[7:0]);
            3'b101:  ext = DATA_W'(shifted[15:0]);
            3'b110:  ext = DATA_W'(shifted[31:0]);
            default: ext = shifted;
        endcase
    end

    // Store data is replicated across lanes so that the strobes alone pick the bytes.
    always_comb begin
        size_mask = {NB{1'b1}};
        rep_wdata = lat_wdata;
        case (lat_f3[1:0])
            2'b00: begin
                size_mask = NB'(1);
                rep_wdata = {NB{lat_wdata[7:0]}};
            end
            2'b01: begin
                size_mask = NB'(3);
                rep_wdata = {(NB / 2){lat_wdata[15:0]}};
            end
            2'b10: begin
                size_mask = NB'(15);
                rep_wdata = {(NB / 4){lat_wdata[31:0]}};
            end
            default: begin
                size_mask = {NB{1'b1}};
                rep_wdata = lat_wdata;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign stall     = accept || (state_q == BUS);
    assign done      = (state_q == RESP);
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign mem_valid = (state_q == BUS);
    assign mem_we    = (state_q == BUS) && lat_store;
    assign mem_addr  = {lat_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_wdata = rep_wdata;
    assign mem_wstrb = ((state_q == BUS) && lat_store) ? (size_mask << lat_off) : '0;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_lsu_handshake.sv
module tb_lsu_handshake;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    int          sel;

    // Per-instance gated handshakes: only the selected instance sees traffic.
    logic rv_a, rv_t, rv_w, mr_a, mr_t, mr_w;
    assign rv_a = req_valid && (sel == 0);
    assign rv_t = req_valid && (sel == 1);
    assign rv_w = req_valid && (sel == 2);
    assign mr_a = mem_ready && (sel == 0);
    assign mr_t = mem_ready && (sel == 1);
    assign mr_w = mem_ready && (sel == 2);

    // Instance a: 32-bit, default timeout. Instance t: 32-bit, TIMEOUT=4. Instance w: 64-bit.
    logic        rr_a, dn_a, st_a, mv_a, we_a;
    logic [1:0]  ft_a, sd_a;
    logic [31:0] rd_a, ma_a, wd_a;
    logic [3:0]  sb_a;
    logic        rr_t, dn_t, st_t, mv_t, we_t;
    logic [1:0]  ft_t, sd_t;
    logic [31:0] rd_t, ma_t, wd_t;
    logic [3:0]  sb_t;
    logic        rr_w, dn_w, st_w, mv_w, we_w;
    logic [1:0]  ft_w, sd_w;
    logic [63:0] rd_w, wd_w;
    logic [31:0] ma_w;
    logic [7:0]  sb_w;

    lsu_handshake u_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(rr_a), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata[31:0]),
        .rdata(rd_a), .done(dn_a), .fault(ft_a), .stall(st_a), .mem_valid(mv_a),
        .mem_ready(mr_a), .mem_we(we_a), .mem_addr(ma_a), .mem_wdata(wd_a),
        .mem_wstrb(sb_a), .mem_rdata(mem_rdata[31:0]), .state_dbg(sd_a)
    );

    lsu_handshake #(.TIMEOUT(4)) u_t (
        .clk(clk), .rst(rst), .req_valid(rv_t), .req_ready(rr_t), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata[31:0]),
        .rdata(rd_t), .done(dn_t), .fault(ft_t), .stall(st_t), .mem_valid(mv_t),
        .mem_ready(mr_t), .mem_we(we_t), .mem_addr(ma_t), .mem_wdata(wd_t),
        .mem_wstrb(sb_t), .mem_rdata(mem_rdata[31:0]), .state_dbg(sd_t)
    );

    lsu_handshake #(.DATA_W(64)) u_w (
        .clk(clk), .rst(rst), .req_valid(rv_w), .req_ready(rr_w), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rd_w), .done(dn_w), .fault(ft_w), .stall(st_w), .mem_valid(mv_w),
        .mem_ready(mr_w), .mem_we(we_w), .mem_addr(ma_w), .mem_wdata(wd_w),
        .mem_wstrb(sb_w), .mem_rdata(mem_rdata), .state_dbg(sd_w)
    );

    // Observed outputs of the selected instance, zero-extended to common widths.
    logic        o_rr, o_dn, o_st, o_mv, o_we;
    logic [1:0]  o_ft;
    logic [63:0] o_rd, o_wd;
    logic [31:0] o_ma;
    logic [7:0]  o_sb;
    always_comb begin
        o_rr = rr_a; o_dn = dn_a; o_st = st_a; o_mv = mv_a; o_we = we_a; o_ft = ft_a;
        o_rd = {32'b0, rd_a}; o_wd = {32'b0, wd_a}; o_ma = ma_a; o_sb = {4'b0, sb_a};
        case (sel)
            1: begin
                o_rr = rr_t; o_dn = dn_t; o_st = st_t; o_mv = mv_t; o_we = we_t; o_ft = ft_t;
                o_rd = {32'b0, rd_t}; o_wd = {32'b0, wd_t}; o_ma = ma_t; o_sb = {4'b0, sb_t};
            end
            2: begin
                o_rr = rr_w; o_dn = dn_w; o_st = st_w; o_mv = mv_w; o_we = we_w; o_ft = ft_w;
                o_rd = rd_w; o_wd = wd_w; o_ma = ma_w; o_sb = sb_w;
            end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_rdata [3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 2) ? 64 : 32;
    endfunction

    function automatic int timeout_of(input int s);
        return (s == 1) ? 4 : 255;
    endfunction

    // Reference model: what a single access should produce, from the access rules.
    function automatic void model(input int w, input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [63:0] wd, input logic [63:0] bus,
                                  output logic [1:0] flt, output logic [63:0] ldv,
                                  output logic [31:0] ma, output logic [63:0] mwd,
                                  output logic [7:0] strb);
        int nb, sz, off;
        bit legal;
        logic [63:0] b, mask;
        nb  = w / 8;
        sz  = 1 << f3[1:0];
        off = int'(a[2:0]) % nb;
        if (ld && st) legal = 0;
        else if (ld) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5) ||
                             ((w == 64) && ((f3 == 3) || (f3 == 6)));
        else legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || ((w == 64) && (f3 == 3));
        if (!legal) flt = 2'b11;
        else if ((int'(a[2:0]) % sz) != 0) flt = 2'b01;
        else flt = 2'b00;
        ma   = a - 32'(off);
        strb = 8'(((1 << sz) - 1) << off);
        mwd  = '0;
        for (int i = 0; i < nb; i++) mwd[8*i +: 8] = wd[8*(i % sz) +: 8];
        b   = (w == 32) ? (bus & 64'hFFFF_FFFF) : bus;
        ldv = b >> (8 * off);
        if (sz < 8) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            ldv  = ldv & mask;
            if (!f3[2] && ldv[8*sz-1]) ldv = ldv | ~mask;
        end
        if (w == 32) ldv = ldv & 64'hFFFF_FFFF;
    endfunction

    // One complete access on instance s, with 'waits' cycles of mem_ready low.
    task automatic run_txn(input int s, input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [63:0] wd, input logic [63:0] bus,
                           input int waits);
        logic [1:0]  ef;
        logic [63:0] lv, ewd;
        logic [31:0] ea;
        logic [7:0]  es;
        int          to, ncyc;
        bit          exp_to;
        model(width_of(s), ld, st, f3, a, wd, bus, ef, lv, ea, ewd, es);
        to = timeout_of(s);
        @(negedge clk);
        sel = s;
        req_valid = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 0; mem_rdata = bus;
        #1;
        check("req_ready_acc", o_rr, 1);
        check("stall_acc", o_st, 1);
        @(negedge clk);
        // Scramble request fields: the unit must work from its latched copy.
        req_valid = 0; is_load = 1'($urandom); is_store = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; wdata = {$urandom, $urandom};
        #1;
        if (ef != 2'b00) begin
            check("flt_done", o_dn, 1);
            check("flt_code", o_ft, ef);
            check("flt_no_bus", o_mv, 0);
            check("flt_stall", o_st, 0);
            check("flt_rdata", o_rd, exp_rdata[s]);
        end else begin
            exp_to = (to != 0) && (waits >= to);
            ncyc   = exp_to ? to : waits + 1;
            for (int k = 0; k < ncyc; k++) begin
                check("bus_valid", o_mv, 1);
                check("bus_stall", o_st, 1);
                check("bus_done", o_dn, 0);
                check("bus_addr", o_ma, ea);
                check("bus_we", o_we, st);
                check("bus_wstrb", o_sb, st ? es : 8'h00);
                if (st) check("bus_wdata", o_wd, ewd);
                mem_ready = (k == waits);
                mem_rdata = (k == waits) ? bus : {$urandom, $urandom};
                @(negedge clk);
                #1;
            end
            // After a timeout, a late ready must change nothing.
            mem_ready = exp_to;
            mem_rdata = {$urandom, $urandom};
            #1;
            if (ld && !exp_to) exp_rdata[s] = lv;
            check("resp_done", o_dn, 1);
            check("resp_valid", o_mv, 0);
            check("resp_stall", o_st, 0);
            check("resp_fault", o_ft, exp_to ? 2'b10 : 2'b00);
            check("resp_rdata", o_rd, exp_rdata[s]);
        end
        @(negedge clk);
        #1;
        check("post_done", o_dn, 0);
        check("post_ready", o_rr, 1);
        check("post_valid", o_mv, 0);
        check("post_rdata", o_rd, exp_rdata[s]);
        mem_ready = 0;
    endtask

    initial begin
        int r, sz, nb, wt;
        bit ld, st;
        logic [2:0]  f3;
        logic [31:0] a;
        rst = 0; req_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0;
        wdata = 0; mem_rdata = 0; mem_ready = 0; sel = 0;
        for (int s = 0; s < 3; s++) exp_rdata[s] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_ready", o_rr, 1);
            check("rst_valid", o_mv, 0);
            check("rst_we", o_we, 0);
            check("rst_done", o_dn, 0);
            check("rst_stall", o_st, 0);
            check("rst_fault", o_ft, 0);
            check("rst_rdata", o_rd, 0);
            check("rst_wstrb", o_sb, 0);
        end
        @(negedge clk);
        rst = 1;

        // Directed accesses.
        run_txn(0, 1, 0, 3'b000, 32'h0000_1003, 64'h0, 64'h80FF_1234, 0);       // LB
        check("lb_value", o_rd, 64'hFFFF_FF80);
        run_txn(0, 0, 1, 3'b001, 32'h0000_2002, 64'h0000_ABCD, 64'h0, 5);       // SH
        run_txn(0, 1, 0, 3'b010, 32'h0000_1001, 64'h0, 64'h1234_5678, 0);       // misaligned LW
        run_txn(0, 1, 1, 3'b010, 32'h0000_1000, 64'h0, 64'h0, 0);               // load+store
        run_txn(1, 1, 0, 3'b010, 32'h0000_0100, 64'h0, 64'h5555_AAAA, 100);     // timeout
        run_txn(1, 1, 0, 3'b010, 32'h0000_0104, 64'h0, 64'h7654_3210, 3);       // just under timeout
        run_txn(2, 1, 0, 3'b110, 32'h0000_0104, 64'h0, 64'h8000_0001_0000_0000, 0); // LWU
        check("lwu_value", o_rd, 64'h0000_0000_8000_0001);
        run_txn(2, 0, 1, 3'b011, 32'h0000_0108, 64'h0123_4567_89AB_CDEF, 64'h0, 1); // SD
        run_txn(2, 1, 0, 3'b011, 32'h0000_0110, 64'h0, 64'hFEDC_BA98_7654_3210, 2); // LD
        run_txn(0, 1, 0, 3'b011, 32'h0000_0000, 64'h0, 64'h0, 0);               // LD on 32-bit

        // Asynchronous reset in the middle of a bus transaction.
        @(negedge clk);
        sel = 0; req_valid = 1; is_load = 1; is_store = 0; funct3 = 3'b010;
        addr = 32'h0000_0040; mem_ready = 0;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        #1;
        check("mid_valid_before", o_mv, 1);
        req_valid = 1;
        #1;
        rst = 0;
        #1;
        for (int s = 0; s < 3; s++) exp_rdata[s] = '0;
        check("mid_rst_valid", o_mv, 0);
        check("mid_rst_stall", o_st, 0);
        check("mid_rst_done", o_dn, 0);
        check("mid_rst_rdata", o_rd, 0);
        check("mid_rst_ready", o_rr, 1);
        @(negedge clk);
        req_valid = 0;
        rst = 1;
        #1;
        check("post_rst_ready", o_rr, 1);
        run_txn(0, 1, 0, 3'b010, 32'h0000_0040, 64'h0, 64'hCAFE_F00D, 1);

        // Randomized accesses on every instance.
        for (int s = 0; s < 3; s++) begin
            nb = width_of(s) / 8;
            for (int n = 0; n < 40; n++) begin
                r  = $urandom_range(0, 9);
                ld = (r == 0) || (r < 6);
                st = (r == 0) || (r >= 6);
                f3 = 3'($urandom_range(0, 7));
                sz = 1 << f3[1:0];
                a  = $urandom & 32'hFFFF_FFF8;
                if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 7));
                else if (sz <= nb) a = a + 32'(sz * $urandom_range(0, nb / sz - 1));
                wt = $urandom_range(0, (s == 1) ? 6 : 3);
                run_txn(s, ld, st, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, wt);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
